// File: rtl/dmem_responder.sv
// Data-port memory responder: one request in flight, programmable wait states, registered response.
// Define DMEM_MMIO_EN to decode the console (0x0) and halt (0x4) words instead of RAM words 0/1.
module dmem_responder #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        console_valid,
  output logic [31:0] console_data,
  output logic        halt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic              we_reg;
  logic [31:0]       addr_reg, wdata_reg;
  logic [3:0]        be_reg;
  logic [31:0]       rdata_reg, rdata_next;
  logic              err_reg, err_next;
  logic              access;
  logic              addr_err;
  logic              ram_we;
  logic              mmio_hit;
  logic [31:0]       mmio_rdata;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       ram_word;

  assign word_idx = addr_reg[ADDR_W+1:2];
  assign addr_err = (addr_reg[1:0] != 2'b00) || (addr_reg[31:ADDR_W+2] != '0);
  assign ram_we   = access && we_reg && !addr_err && !mmio_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 8'd0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      be_reg    <= 4'd0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      if (state_reg == S_IDLE && req_valid) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        be_reg    <= req_be;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    access     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          state_next = S_WAIT;
          cnt_next   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else begin
          access     = 1'b1;
          state_next = S_RESP;
          err_next   = addr_err;
          // Stores and faulting accesses return zero data.
          if (addr_err || we_reg)
            rdata_next = 32'd0;
          else if (mmio_hit)
            rdata_next = mmio_rdata;
          else
            rdata_next = ram_word;
        end
      end
      S_RESP: begin
        if (rsp_ready)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  // One array per byte lane so each lane's write enable stays independent.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (ram_we && be_reg[gi])
          lane_mem[word_idx] <= wdata_reg[8*gi +: 8];
      end
      assign ram_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

`ifdef DMEM_MMIO_EN
  logic        console_valid_reg;
  logic [31:0] console_data_reg;
  logic        halt_reg;
  logic        mmio_store;

  assign mmio_hit   = (addr_reg[31:3] == 29'd0);
  assign mmio_rdata = addr_reg[2] ? {31'd0, halt_reg} : console_data_reg;
  assign mmio_store = access && we_reg && !addr_err && mmio_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      console_valid_reg <= 1'b0;
      console_data_reg  <= 32'd0;
      halt_reg          <= 1'b0;
    end else begin
      console_valid_reg <= mmio_store && !addr_reg[2];
      if (mmio_store && !addr_reg[2])
        console_data_reg <= wdata_reg;
      if (mmio_store && addr_reg[2])
        halt_reg <= 1'b1;
    end
  end

  assign console_valid = console_valid_reg;
  assign console_data  = console_data_reg;
  assign halt          = halt_reg;
`else
  assign mmio_hit      = 1'b0;
  assign mmio_rdata    = 32'd0;
  assign console_valid = 1'b0;
  assign console_data  = 32'd0;
  assign halt          = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 side instance).
// MMIO checks follow whether DMEM_MMIO_EN is defined for the build.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic        console_valid, halt;
  logic [31:0] req_addr, req_wdata, rsp_rdata, console_data;
  logic [3:0]  req_be;
  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic        z_console_valid, z_halt;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata, z_console_data;
  logic [3:0]  z_req_be;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .console_valid(console_valid), .console_data(console_data), .halt(halt));

  dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be), .rsp_valid(z_rsp_valid),
    .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
    .console_valid(z_console_valid), .console_data(z_console_data), .halt(z_halt));

  // Full transaction on the main instance; lat = edges from acceptance to rsp_valid.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] rd, output logic er, output int lat, output logic cv);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata; er = rsp_err; cv = console_valid;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    $display("xact we=%0b addr=%08h wdata=%08h be=%04b -> rdata=%08h err=%0b lat=%0d", we, a, d, be, rd, er, lat);
  endtask

  task automatic xact0(input logic we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int lat);
    int n = 0;
    z_req_valid = 1'b1; z_req_we = we; z_req_addr = a; z_req_wdata = d; z_req_be = 4'hF;
    while (!z_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    lat = 0;
    while (!z_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = z_rsp_rdata;
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_rsp_ready = 1'b0;
    $display("xact0 we=%0b addr=%08h wdata=%08h -> rdata=%08h lat=%0d", we, a, d, rd, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 7;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata got=%08h exp=0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    if (console_valid !== 1'b0) begin n_fail++; $display("FAIL reset_console_valid got=%b exp=0", console_valid); end
    if (console_data !== 32'd0) begin n_fail++; $display("FAIL reset_console_data got=%08h exp=0", console_data); end
    if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got=%b exp=0", halt); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er, cv; int lat;
    xact(1'b1, 32'h10, 32'h12345678, 4'hF, rd, er, lat, cv);
    n_checks += 3;
    if (lat !== 3) begin n_fail++; $display("FAIL store_latency got=%0d exp=3", lat); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL store_err got=%b exp=0", er); end
    if (rd !== 32'd0) begin n_fail++; $display("FAIL store_rdata got=%08h exp=0", rd); end
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks += 3;
    if (lat !== 3) begin n_fail++; $display("FAIL load_latency got=%0d exp=3", lat); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL load_err got=%b exp=0", er); end
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL load_rdata got=%08h exp=12345678", rd); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er, cv; int lat;
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, rd, er, lat, cv);
    xact(1'b1, 32'h20, 32'h00000011, 4'b0001, rd, er, lat, cv);
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (rd !== 32'hAABBCC11) begin n_fail++; $display("FAIL lane0_merge got=%08h exp=AABBCC11", rd); end
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat, cv);
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (rd !== 32'hAABBCC11) begin n_fail++; $display("FAIL be0_noop got=%08h exp=AABBCC11", rd); end
    xact(1'b1, 32'h20, 32'h55667788, 4'b1010, rd, er, lat, cv);
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (rd !== 32'h55BB7711) begin n_fail++; $display("FAIL lane31_merge got=%08h exp=55BB7711", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, cv; int lat;
    xact(1'b1, 32'h40, 32'h11223344, 4'hF, rd, er, lat, cv);
`ifndef DMEM_MMIO_EN
    xact(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, rd, er, lat, cv);
`endif
    xact(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks += 2;
    if (er !== 1'b1) begin n_fail++; $display("FAIL misaligned_err got=%b exp=1", er); end
    if (rd !== 32'd0) begin n_fail++; $display("FAIL misaligned_rdata got=%08h exp=0", rd); end
    xact(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat, cv);
    n_checks += 2;
    if (er !== 1'b1) begin n_fail++; $display("FAIL range_store_err got=%b exp=1", er); end
    if (rd !== 32'd0) begin n_fail++; $display("FAIL range_store_rdata got=%08h exp=0", rd); end
    xact(1'b1, 32'h440, 32'hFFFFFFFF, 4'hF, rd, er, lat, cv);
    xact(1'b1, 32'h42, 32'hFFFFFFFF, 4'hF, rd, er, lat, cv);
    xact(1'b0, 32'h80000040, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL high_addr_err got=%b exp=1", er); end
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks += 2;
    if (rd !== 32'h11223344) begin n_fail++; $display("FAIL word16_intact got=%08h exp=11223344", rd); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL word16_err got=%b exp=0", er); end
`ifndef DMEM_MMIO_EN
    xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (rd !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL word0_intact got=%08h exp=5A5A5A5A", rd); end
`endif
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic er, cv; int lat;
    int n = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    // A store offered while the response is stalled must not be queued.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
    for (int c = 0; c < 5; c++) begin
      n_checks += 3;
      if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", c, rsp_valid); end
      if (rsp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL stall_rdata cyc=%0d got=%08h exp=12345678", c, rsp_rdata); end
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_req_ready cyc=%0d got=%b exp=0", c, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    $display("stall load addr=00000010 released after 5 held cycles");
    n_checks += 2;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid got=%b exp=0", rsp_valid); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready got=%b exp=1", req_ready); end
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL no_queue_rdata got=%08h exp=12345678", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, cv; int lat;
    logic seen = 1'b0;
    xact(1'b1, 32'h30, 32'h77777777, 4'hF, rd, er, lat, cv);
    xact(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat, cv);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h99999999; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    $display("reset asserted with store addr=00000030 in wait");
    n_checks += 4;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_req_ready got=%b exp=1", req_ready); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid got=%b exp=0", rsp_valid); end
    if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_rsp_rdata got=%08h exp=0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_err got=%b exp=0", rsp_err); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_response got=%b exp=0", seen); end
    xact(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (rd !== 32'h77777777) begin n_fail++; $display("FAIL midrst_not_written got=%08h exp=77777777", rd); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; int lat;
    xact0(1'b1, 32'h8, 32'hDEADBEEF, rd, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL w0_store_latency got=%0d exp=1", lat); end
    xact0(1'b0, 32'h8, 32'h0, rd, lat);
    n_checks += 2;
    if (lat !== 1) begin n_fail++; $display("FAIL w0_load_latency got=%0d exp=1", lat); end
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL w0_load_rdata got=%08h exp=DEADBEEF", rd); end
  endtask

  task automatic test_mmio();
    logic [31:0] rd; logic er, cv; int lat;
`ifdef DMEM_MMIO_EN
    xact(1'b1, 32'h0, 32'h7, 4'b0001, rd, er, lat, cv);
    n_checks += 3;
    if (cv !== 1'b1) begin n_fail++; $display("FAIL console_pulse got=%b exp=1", cv); end
    if (console_valid !== 1'b0) begin n_fail++; $display("FAIL console_pulse_width got=%b exp=0", console_valid); end
    if (console_data !== 32'h7) begin n_fail++; $display("FAIL console_data got=%08h exp=7", console_data); end
    xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (rd !== 32'h7) begin n_fail++; $display("FAIL console_load got=%08h exp=7", rd); end
    xact(1'b1, 32'h4, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_set got=%b exp=1", halt); end
    xact(1'b1, 32'h40, 32'h1, 4'hF, rd, er, lat, cv);
    xact(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks += 2;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL halt_load got=%08h exp=1", rd); end
    if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_sticky got=%b exp=1", halt); end
`else
    xact(1'b1, 32'h0, 32'h7, 4'hF, rd, er, lat, cv);
    xact(1'b1, 32'h4, 32'h9, 4'hF, rd, er, lat, cv);
    n_checks += 3;
    if (cv !== 1'b0) begin n_fail++; $display("FAIL plain_console_valid got=%b exp=0", cv); end
    if (console_data !== 32'd0) begin n_fail++; $display("FAIL plain_console_data got=%08h exp=0", console_data); end
    if (halt !== 1'b0) begin n_fail++; $display("FAIL plain_halt got=%b exp=0", halt); end
    xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (rd !== 32'h7) begin n_fail++; $display("FAIL plain_word0 got=%08h exp=7", rd); end
    xact(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat, cv);
    n_checks++;
    if (rd !== 32'h9) begin n_fail++; $display("FAIL plain_word1 got=%08h exp=9", rd); end
`endif
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0; z_req_be = 4'd0;
    z_rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_stall();
    test_reset_mid();
    test_zero_wait();
    test_mmio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
